stream_demux_n: RTL

- Parametrised, registered 1-to-N stream demultiplexer with per-channel valid/ready handshake.
- Routes each input word to the output channel given by its select field, or to all channels in broadcast mode.
- Each output channel has a single-entry output register.
- Words with an out-of-range select are dropped and counted.
- Sits between a single producer and N independent consumers in the FPGA lab datapath. It is the sequential, flow-controlled successor to the plain combinational 1-to-4 demux.

---
 rtl/stream_demux_n_if.sv | 26 ++
 rtl/stream_demux_n.sv | 82 ++++++++
 2 files changed

// File: rtl/stream_demux_n_if.sv
// Stream bundle for stream_demux_n: one producer-side handshake and NCH consumer-side handshakes.
// The demux uses the slave modport and the producer/consumer side uses master.
interface stream_demux_n_if #(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int SW  = 2
);
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic [SW-1:0]     s_sel;
    logic              s_bcast;
    logic [NCH-1:0]    m_valid;
    logic [NCH-1:0]    m_ready;
    logic [NCH*DW-1:0] m_data;

    modport slave (
        input  s_valid, s_data, s_sel, s_bcast, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, s_sel, s_bcast, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/stream_demux_n.sv
// Registered 1-to-NCH stream demultiplexer with per-channel valid/ready, broadcast,
// and a saturating counter of words dropped for an out-of-range select.
module stream_demux_n #(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int SW  = 2,
    parameter int CW  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_demux_n_if.slave     bus,
    input  logic                clr_drop,
    output logic [CW-1:0]       drop_cnt
);
    localparam int          NSEL  = 2 ** SW;
    localparam logic [SW:0] NCH_W = (SW + 1)'(NCH);

    logic [NCH-1:0]    m_valid_q, m_valid_d;
    logic [NCH*DW-1:0] m_data_q,  m_data_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

    logic [NCH-1:0]    free;
    logic [NSEL-1:0]   free_ext;
    logic [NCH-1:0]    load;
    logic              sel_ok;
    logic              accept;
    logic              drop;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        free     = '0;
        free_ext = '1;
        load     = '0;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        drop_cnt_d = drop_cnt_q;

        for (int i = 0; i < NCH; i++) begin
            free[i]     = !m_valid_q[i] || bus.m_ready[i];
            free_ext[i] = free[i];
        end

        // Unused select codes read as free, so an out-of-range word is always accepted and dropped.
        sel_ok      = ({1'b0, bus.s_sel} < NCH_W);
        bus.s_ready = bus.s_bcast ? (&free) : free_ext[bus.s_sel];
        accept      = bus.s_valid && bus.s_ready;
        drop        = accept && !bus.s_bcast && !sel_ok;

        for (int i = 0; i < NCH; i++) begin
            load[i] = accept && (bus.s_bcast || (bus.s_sel == SW'(i)));
            // A reload wins over a same-cycle drain, keeping the slot valid with the new word.
            m_valid_d[i] = load[i] || (m_valid_q[i] && !bus.m_ready[i]);
            if (load[i]) begin
                m_data_d[i*DW +: DW] = bus.s_data;
            end
        end

        if (clr_drop) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q  <= '0;
            // NOTE: the data slots are plain flops, not RAM, so they are cleared on reset too.
            m_data_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign drop_cnt    = drop_cnt_q;
endmodule
